// File: rtl/sr_pkg.sv
// -----------------------------------------------------------------------------
// sr_pkg
// Shared definitions for the clocked SR flip-flop bank.
//   - MODE_* : conflict-resolution policies applied when set and reset are
//              both asserted on an enabled channel.
//   - sr_next: next-state function of one active-high SR/JK cell.
// No ports (package).
// -----------------------------------------------------------------------------
package sr_pkg;

  localparam int MODE_HOLD    = 0;
  localparam int MODE_SET_DOM = 1;
  localparam int MODE_RST_DOM = 2;
  localparam int MODE_TOGGLE  = 3;

  // Next value of one cell given the current state and active-high requests.
  // The 2'b11 column is the only place where the build-time policy matters.
  function automatic logic sr_next(input int   mode,
                                   input logic q,
                                   input logic sa,
                                   input logic ra);
    logic nxt;
    case ({sa, ra})
      2'b00: nxt = q;
      2'b10: nxt = 1'b1;
      2'b01: nxt = 1'b0;
      2'b11: begin
        case (mode)
          MODE_HOLD:    nxt = q;
          MODE_SET_DOM: nxt = 1'b1;
          MODE_RST_DOM: nxt = 1'b0;
          MODE_TOGGLE:  nxt = ~q;
          default:      nxt = q;
        endcase
      end
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// -----------------------------------------------------------------------------
// sr_cell
// One clocked SR flip-flop channel with active-high (already normalised)
// requests and a per-channel enable.
// Ports:
//   clk          in  1  clock, rising edge
//   rst_n        in  1  synchronous active-low reset
//   en           in  1  update enable
//   sa           in  1  set request, active-high
//   ra           in  1  reset request, active-high
//   q            out 1  registered state
//   changed      out 1  registered pulse: q took a new value on the last edge
//   conflict_evt out 1  combinational: enabled cell sees set and reset together
// -----------------------------------------------------------------------------
module sr_cell
  import sr_pkg::*;
#(
  parameter int MODE  = MODE_HOLD,
  parameter int RST_Q = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sa,
  input  logic ra,
  output logic q,
  output logic changed,
  output logic conflict_evt
);

  localparam logic RST_BIT = (RST_Q != 0) ? 1'b1 : 1'b0;

  logic r_q;
  logic r_changed;
  logic w_q_next;
  logic w_conflict_evt;

  // Next-state selection; a disabled cell simply holds.
  always_comb begin
    w_q_next       = r_q;
    w_conflict_evt = 1'b0;
    if (en) begin
      w_q_next       = sr_next(MODE, r_q, sa, ra);
      w_conflict_evt = sa & ra;
    end else begin
      w_q_next       = r_q;
      w_conflict_evt = 1'b0;
    end
  end

  // State and change-pulse registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q       <= RST_BIT;
      r_changed <= 1'b0;
    end else begin
      r_q       <= w_q_next;
      r_changed <= w_q_next ^ r_q;
    end
  end

  assign q            = r_q;
  assign changed      = r_changed;
  assign conflict_evt = w_conflict_evt;

endmodule

// File: rtl/sr_ff_bank.sv
// -----------------------------------------------------------------------------
// sr_ff_bank
// Bank of N independent clocked SR flip-flops with build-time conflict policy,
// selectable input polarity, sticky per-channel conflict flags and a
// saturating count of cycles that contained at least one enabled conflict.
// Ports:
//   clk           in  1      clock, rising edge
//   rst_n         in  1      synchronous active-low reset
//   en            in  N      per-channel update enable, active-high
//   s             in  N      set request (active-low when ACTIVE_LOW=1)
//   r             in  N      reset request (active-low when ACTIVE_LOW=1)
//   clr_conflict  in  1      clears sticky flags and counter
//   q             out N      registered state
//   q_bar         out N      complement of q
//   changed       out N      one-cycle pulse per bit that changed
//   conflict      out N      sticky enabled-conflict flags
//   conflict_cnt  out CNT_W  saturating conflict-cycle counter
// -----------------------------------------------------------------------------
module sr_ff_bank
  import sr_pkg::*;
#(
  parameter int N          = 8,
  parameter int MODE       = MODE_HOLD,
  parameter int ACTIVE_LOW = 1,
  parameter int CNT_W      = 8,
  parameter int RST_Q      = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     en,
  input  logic [N-1:0]     s,
  input  logic [N-1:0]     r,
  input  logic             clr_conflict,
  output logic [N-1:0]     q,
  output logic [N-1:0]     q_bar,
  output logic [N-1:0]     changed,
  output logic [N-1:0]     conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  // Refuse to build with an unsupported policy or channel count.
  generate
    if (MODE < 0 || MODE > 3 || N < 1 || N > 32) begin : g_bad_param
      $error("sr_ff_bank: MODE must be 0..3 and N must be 1..32");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [N-1:0]     w_sa;
  logic [N-1:0]     w_ra;
  logic [N-1:0]     w_q;
  logic [N-1:0]     w_changed;
  logic [N-1:0]     w_evt;
  logic             w_any_evt;
  logic [N-1:0]     w_conflict_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [N-1:0]     r_conflict;
  logic [CNT_W-1:0] r_cnt;

  // Bring both request buses to active-high so the cells never see polarity.
  always_comb begin
    w_sa = s;
    w_ra = r;
    if (ACTIVE_LOW != 0) begin
      w_sa = ~s;
      w_ra = ~r;
    end else begin
      w_sa = s;
      w_ra = r;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cell
      sr_cell #(
        .MODE  (MODE),
        .RST_Q (RST_Q)
      ) u_cell (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en[gi]),
        .sa           (w_sa[gi]),
        .ra           (w_ra[gi]),
        .q            (w_q[gi]),
        .changed      (w_changed[gi]),
        .conflict_evt (w_evt[gi])
      );
    end
  endgenerate

  assign w_any_evt = |w_evt;

  // Sticky flags and counter next values; a fresh conflict beats a clear.
  always_comb begin
    w_conflict_next = r_conflict | w_evt;
    w_cnt_next      = r_cnt;
    if (clr_conflict) begin
      w_conflict_next = w_evt;
      w_cnt_next      = w_any_evt ? CNT_ONE : {CNT_W{1'b0}};
    end else if (w_any_evt && (r_cnt != CNT_MAX)) begin
      w_conflict_next = r_conflict | w_evt;
      w_cnt_next      = r_cnt + CNT_ONE;
    end else begin
      w_conflict_next = r_conflict | w_evt;
      w_cnt_next      = r_cnt;
    end
  end

  // Conflict flag and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_conflict <= {N{1'b0}};
      r_cnt      <= {CNT_W{1'b0}};
    end else begin
      r_conflict <= w_conflict_next;
      r_cnt      <= w_cnt_next;
    end
  end

  assign q            = w_q;
  assign q_bar        = ~w_q;
  assign changed      = w_changed;
  assign conflict     = r_conflict;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Self-checking bench: four banks (one per conflict policy) share stimulus.
module tb_sr_ff_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] en, s, r;
  logic       clr;

  logic [7:0] q_o   [4];
  logic [7:0] qb_o  [4];
  logic [7:0] chg_o [4];
  logic [7:0] cf_o  [4];
  logic [3:0] cnt_o [4];

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    sr_ff_bank #(.N(8), .MODE(m), .ACTIVE_LOW(1), .CNT_W(4), .RST_Q(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .clr_conflict(clr),
      .q(q_o[m]), .q_bar(qb_o[m]), .changed(chg_o[m]), .conflict(cf_o[m]),
      .conflict_cnt(cnt_o[m]));
  end

  typedef struct packed {
    logic [3:0][7:0] q;
    logic [3:0][7:0] chg;
    logic [3:0][7:0] cf;
    logic [3:0][3:0] cnt;
  } exp_t;

  typedef struct packed {
    logic [7:0] en, s, r;
    logic       clr;
    logic [7:0] q, chg;
  } vec_t;

  exp_t       sb_q[$];
  logic [7:0] mq [4];
  logic [7:0] mcf[4];
  logic [3:0] mcnt[4];
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic ref_next(int mode, logic qb, logic sab, logic rab);
    if (sab && !rab) return 1'b1;
    if (!sab && rab) return 1'b0;
    if (!sab && !rab) return qb;
    case (mode)
      1: return 1'b1;
      2: return 1'b0;
      3: return ~qb;
      default: return qb;
    endcase
  endfunction

  // Predict the edge from the current inputs, push, clock, then pop and compare.
  task automatic step(input string tag);
    exp_t e;
    logic [7:0] sa, ra, nq, evt;
    sa = ~s;
    ra = ~r;
    for (int m = 0; m < 4; m++) begin
      if (!rst_n) begin
        e.chg[m] = 8'h00; mq[m] = 8'h00; mcf[m] = 8'h00; mcnt[m] = 4'd0;
      end else begin
        for (int b = 0; b < 8; b++)
          nq[b] = en[b] ? ref_next(m, mq[m][b], sa[b], ra[b]) : mq[m][b];
        evt = en & sa & ra;
        e.chg[m] = nq ^ mq[m];
        mq[m] = nq;
        mcf[m] = (clr ? 8'h00 : mcf[m]) | evt;
        if (clr) mcnt[m] = (evt != 8'h00) ? 4'd1 : 4'd0;
        else if (evt != 8'h00 && mcnt[m] != 4'd15) mcnt[m] = mcnt[m] + 4'd1;
      end
      e.q[m] = mq[m]; e.cf[m] = mcf[m]; e.cnt[m] = mcnt[m];
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      for (int m = 0; m < 4; m++) begin
        chk($sformatf("%s m%0d q", tag, m),     {24'd0, q_o[m]},   {24'd0, e.q[m]});
        chk($sformatf("%s m%0d q_bar", tag, m), {24'd0, qb_o[m]},  {24'd0, ~e.q[m]});
        chk($sformatf("%s m%0d chg", tag, m),   {24'd0, chg_o[m]}, {24'd0, e.chg[m]});
        chk($sformatf("%s m%0d conf", tag, m),  {24'd0, cf_o[m]},  {24'd0, e.cf[m]});
        chk($sformatf("%s m%0d cnt", tag, m),   {28'd0, cnt_o[m]}, {28'd0, e.cnt[m]});
      end
    end
  endtask

  task automatic drive(input logic [7:0] e_i, input logic [7:0] s_i,
                       input logic [7:0] r_i, input logic c_i);
    en = e_i; s = s_i; r = r_i; clr = c_i;
  endtask

  vec_t tbl[7];
  logic [3:0] exp_conf_q;

  initial begin
    // Non-conflicting vectors: all policies agree, q/changed given for bank 0.
    tbl[0] = '{en:8'hFF, s:8'hFE, r:8'hFF, clr:1'b0, q:8'h01, chg:8'h01};
    tbl[1] = '{en:8'hFF, s:8'hFF, r:8'hFE, clr:1'b0, q:8'h00, chg:8'h01};
    tbl[2] = '{en:8'hFF, s:8'hFF, r:8'hFF, clr:1'b0, q:8'h00, chg:8'h00};
    tbl[3] = '{en:8'h0F, s:8'h00, r:8'hFF, clr:1'b0, q:8'h0F, chg:8'h0F};
    tbl[4] = '{en:8'hF0, s:8'hFF, r:8'h00, clr:1'b0, q:8'h0F, chg:8'h00};
    tbl[5] = '{en:8'hFF, s:8'hFF, r:8'h00, clr:1'b0, q:8'h00, chg:8'h0F};
    tbl[6] = '{en:8'hFF, s:8'hFF, r:8'hFF, clr:1'b0, q:8'h00, chg:8'h00};

    // 1. Reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      step("reset");
    end
    chk("reset q", {24'd0, q_o[0]}, 32'h00);
    chk("reset q_bar", {24'd0, qb_o[0]}, 32'hFF);
    rst_n = 1'b1;

    // 2. Table-driven set/reset
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].en, tbl[i].s, tbl[i].r, tbl[i].clr);
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl q", i),   {24'd0, q_o[0]},   {24'd0, tbl[i].q});
      chk($sformatf("vec%0d tbl chg", i), {24'd0, chg_o[0]}, {24'd0, tbl[i].chg});
    end

    // 3. Conflict on ch0 for 3 cycles
    drive(8'h01, 8'hFE, 8'hFE, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("conflict");
      chk($sformatf("toggle chg c%0d", i), {31'd0, chg_o[3][0]}, 32'd1);
    end
    exp_conf_q = 4'b1010;  // ch0 per mode: HOLD 0, SET 1, RST 0, TOGGLE 1
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("conflict q0 m%0d", m), {31'd0, q_o[m][0]}, {31'd0, exp_conf_q[m]});
      chk($sformatf("conflict flag m%0d", m), {24'd0, cf_o[m]}, 32'h01);
      chk($sformatf("conflict cnt m%0d", m), {28'd0, cnt_o[m]}, 32'd3);
    end

    // 4. Disabled channels ignore conflicts
    drive(8'h00, 8'h00, 8'h00, 1'b0);
    step("gate");
    step("gate");
    chk("gate cnt", {28'd0, cnt_o[1]}, 32'd3);
    chk("gate flag", {24'd0, cf_o[1]}, 32'h01);

    // 5. Counter saturation and clears
    drive(8'hFF, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) step("sat");
    chk("sat cnt", {28'd0, cnt_o[0]}, 32'd15);
    drive(8'h00, 8'hFF, 8'hFF, 1'b1);
    step("clr");
    chk("clr cnt", {28'd0, cnt_o[2]}, 32'd0);
    chk("clr flag", {24'd0, cf_o[2]}, 32'h00);
    drive(8'h04, 8'h00, 8'h00, 1'b1);
    step("clr+conf");
    chk("clr+conf cnt", {28'd0, cnt_o[2]}, 32'd1);
    chk("clr+conf flag", {24'd0, cf_o[2]}, 32'h04);

    // 6. Mid-run reset while toggling
    drive(8'hFF, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step("tog");
    rst_n = 1'b0;
    step("midrst");
    chk("midrst q", {24'd0, q_o[3]}, 32'h00);
    chk("midrst chg", {24'd0, chg_o[3]}, 32'h00);
    chk("midrst cnt", {28'd0, cnt_o[3]}, 32'd0);
    rst_n = 1'b1;
    step("resume");
    chk("resume q", {24'd0, q_o[3]}, 32'hFF);
    step("resume");

    // Random mix
    for (int i = 0; i < 40; i++) begin
      rst_n = ($urandom_range(0, 19) != 0);
      drive(8'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 5) == 0));
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
